// File: rtl/decoder_pkg.sv
// Shared types for the registered one-hot decoder family.
// Holds the FSM state encoding and the mode input constants.
package decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIRECT,
    ST_SCAN
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_scan_n_scan_timer.sv
// Dwell counter for scan mode: tick marks the last cycle of a dwell period.
// tick is combinational from the count and the live dwell; no backpressure.
module scan_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell,
  output logic               tick
);

  logic [DWELL_W-1:0] cnt;

  assign tick = run && (cnt == dwell);

  // A dwell lowered below cnt mid-scan lets cnt roll over before it matches again.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N one-hot decoder with direct and auto-scan modes.
// Latency 1 cycle from inputs to D/idx/wrap; no backpressure, all outputs are flops.
module decoder_scan_n
  import decoder_pkg::*;
#(
  parameter int N       = 3,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [N-1:0]       sel,
  input  logic [DWELL_W-1:0] dwell,
  output logic [(1<<N)-1:0]  D,
  output logic [N-1:0]       idx,
  output logic               wrap
);

  localparam int W = 1 << N;

  state_t       state, state_d;
  logic [N-1:0] idx_d;
  logic         wrap_d;
  logic         scan_hold;
  logic         tick;

  // Only a scan that continues across this edge keeps counting; any other path restarts at 0.
  assign scan_hold = en && (mode == MODE_SCAN) && (state == ST_SCAN);

  scan_timer #(
    .DWELL_W(DWELL_W)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(!scan_hold),
    .run  (scan_hold),
    .dwell(dwell),
    .tick (tick)
  );

  always_comb begin
    state_d = ST_IDLE;
    idx_d   = '0;
    wrap_d  = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
    end else if (mode == MODE_DIRECT) begin
      state_d = ST_DIRECT;
      idx_d   = sel;
    end else if (state != ST_SCAN) begin
      state_d = ST_SCAN;
    end else begin
      state_d = ST_SCAN;
      idx_d   = idx;
      if (tick) begin
        idx_d  = idx + 1'b1;
        wrap_d = &idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      wrap  <= 1'b0;
      D     <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      wrap  <= wrap_d;
      D     <= (state_d == ST_IDLE) ? '0 : (W'(1) << idx_d);
    end
  end

endmodule

// File: tb/tb_decoder_scan_n.sv
// Directed bench for decoder_scan_n at N=3 and N=4 sharing one stimulus stream.
// A scan-position model predicts every output each cycle; literal checks pin key points.
module tb_decoder_scan_n;

  logic        clk = 1'b0;
  logic        rst, en, mode;
  logic [3:0]  sel4;
  logic [7:0]  dwell;
  logic [7:0]  d3;
  logic [2:0]  idx3;
  logic        wrap3;
  logic [15:0] d4;
  logic [3:0]  idx4;
  logic        wrap4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  decoder_scan_n #(.N(3), .DWELL_W(8)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel4[2:0]), .dwell(dwell),
    .D(d3), .idx(idx3), .wrap(wrap3)
  );

  decoder_scan_n #(.N(4), .DWELL_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel4), .dwell(dwell),
    .D(d4), .idx(idx4), .wrap(wrap4)
  );

  // Model: off / direct(sel) / scanning for k cycles since entry.
  int m_st = 0;
  int m_k = 0;
  int m_sel = 0;
  bit model_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_st = 0;
      m_k  = 0;
    end else if (!en) begin
      m_st = 0;
    end else if (mode == 1'b0) begin
      m_st  = 1;
      m_sel = int'(sel4);
    end else if (m_st != 2) begin
      m_st = 2;
      m_k  = 0;
    end else begin
      m_k++;
    end
    model_on = 1'b1;
  end

  function automatic int exp_idx(int n);
    if (m_st == 0) return 0;
    if (m_st == 1) return m_sel % (1 << n);
    return (m_k / (int'(dwell) + 1)) % (1 << n);
  endfunction

  function automatic logic [63:0] exp_d(int n);
    if (m_st == 0) return 64'd0;
    return 64'd1 << exp_idx(n);
  endfunction

  function automatic logic [63:0] exp_wrap(int n);
    return (m_st == 2 && m_k > 0 && (m_k % ((1 << n) * (int'(dwell) + 1))) == 0) ? 64'd1 : 64'd0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      check("model_d3",    64'(d3),    exp_d(3));
      check("model_idx3",  64'(idx3),  64'(exp_idx(3)));
      check("model_wrap3", 64'(wrap3), exp_wrap(3));
      check("model_d4",    64'(d4),    exp_d(4));
      check("model_idx4",  64'(idx4),  64'(exp_idx(4)));
      check("model_wrap4", 64'(wrap4), exp_wrap(4));
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; mode = 1'b1; sel4 = 4'd0; dwell = 8'd2;
    @(negedge clk);
    check("rst_d3", 64'(d3), 64'h0);
    check("rst_idx3", 64'(idx3), 64'h0);
    check("rst_wrap3", 64'(wrap3), 64'h0);
    check("rst_d4", 64'(d4), 64'h0);

    #1 rst = 1'b0;
    @(negedge clk);
    check("scan_entry_d3", 64'(d3), 64'h01);
    check("scan_entry_wrap3", 64'(wrap3), 64'h0);

    repeat (23) @(negedge clk);
    check("scan_last_d3", 64'(d3), 64'h80);
    check("scan_last_wrap3", 64'(wrap3), 64'h0);
    @(negedge clk);
    check("scan_wrap_d3", 64'(d3), 64'h01);
    check("scan_wrap_wrap3", 64'(wrap3), 64'h1);
    check("scan_mid_d4", 64'(d4), 64'h0100);
    check("scan_mid_wrap4", 64'(wrap4), 64'h0);

    repeat (15) @(negedge clk);
    check("scan_idx5_d3", 64'(d3), 64'h20);
    check("scan_idx5_idx3", 64'(idx3), 64'h5);

    #1 mode = 1'b0; sel4 = 4'd2;
    @(negedge clk);
    check("to_direct_d3", 64'(d3), 64'h04);
    check("to_direct_idx3", 64'(idx3), 64'h2);

    #1 mode = 1'b1;
    @(negedge clk);
    check("rescan_d3", 64'(d3), 64'h01);

    repeat (4) @(negedge clk);
    #1 en = 1'b0;
    @(negedge clk);
    check("disable_d3", 64'(d3), 64'h00);
    check("disable_idx3", 64'(idx3), 64'h0);

    #1 en = 1'b1;
    @(negedge clk);
    check("reenable_d3", 64'(d3), 64'h01);

    repeat (2) @(negedge clk);
    #1 en = 1'b0; dwell = 8'd0;
    @(negedge clk);
    #1 en = 1'b1;
    @(negedge clk);
    check("dw0_entry_d3", 64'(d3), 64'h01);
    @(negedge clk);
    check("dw0_step_d3", 64'(d3), 64'h02);
    repeat (7) @(negedge clk);
    check("dw0_wrap_d3", 64'(d3), 64'h01);
    check("dw0_wrap_wrap3", 64'(wrap3), 64'h1);
    check("dw0_d4", 64'(d4), 64'h0100);
    repeat (6) @(negedge clk);
    check("dw0_idx6_d3", 64'(d3), 64'h40);

    #1 rst = 1'b1; dwell = 8'd2;
    @(negedge clk);
    check("midrst_d3", 64'(d3), 64'h00);
    check("midrst_idx3", 64'(idx3), 64'h0);
    check("midrst_wrap3", 64'(wrap3), 64'h0);

    #1 rst = 1'b0;
    @(negedge clk);
    check("postrst_d3", 64'(d3), 64'h01);
    repeat (2) @(negedge clk);
    check("postrst_hold_d3", 64'(d3), 64'h01);
    @(negedge clk);
    check("postrst_step_d3", 64'(d3), 64'h02);

    for (int s = 0; s < 16; s++) begin
      #1 mode = 1'b0; sel4 = 4'(s);
      @(negedge clk);
      check("direct_d3", 64'(d3), 64'd1 << (s % 8));
      check("direct_d4", 64'(d4), 64'd1 << s);
      check("direct_idx4", 64'(idx4), 64'(s));
    end

    #1 en = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
